// File: rtl/ubcd_scan_driver.sv
// ubcd_scan_driver
//   Multiplexed N-digit 7-segment display driver. Holds one 8-bit code per digit
//   (BCD or ASCII), scans the digits from most to least significant and time-shares a
//   single combinational BCD/ASCII segment decoder between them. Adds leading-zero ripple
//   blanking, an anti-ghost dead cycle at the start of every slot, and a frame strobe.
//
// Parameters
//   DIGITS    number of digits scanned (2..16)
//   PRESCALE  clock cycles per digit slot, including the dead cycle (>= 4)
//   AW        write-address width, derived from DIGITS (do not override)
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous reset, active-low
//   we      write strobe; captures wdata into digit waddr on the same edge
//   waddr   digit index, 0 = LSD; addresses >= DIGITS are ignored
//   wdata   [7] = ASCII mode, [6:0] = code (BCD mode uses [3:0])
//   rbz     1 = suppress leading zeros in BCD digits
//   lt_n    0 = lamp test, every scanned digit shows all segments lit
//   blank   1 = force seg to 0 (scan keeps running)
//   blink   (only with UBCD_SCAN_BLINK_EN) per-digit blink enable
//   seg     {g,f,e,d,c,b,a}, active-high, registered
//   dig     one-hot digit enable, active-high, registered
//   frame   one-cycle pulse on the first cycle of the slot of digit 0
//
// Configuration
//   UBCD_SCAN_BLINK_EN  adds the blink port and a 5-bit frame counter; a digit with
//                       blink[i]=1 is dark while frame_cnt[4]=1.
//
// Decoder notes
//   BLANK has the highest priority, then lamp test, then the glyph. Ripple-blank out (RBO)
//   depends only on RBI and the code, so blanked, lamp-tested or blinked digits still
//   propagate it. BCD values 10..15 show no segments.

module ubcd_scan_driver #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned AW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [7:0]        wdata,
    input  logic              rbz,
    input  logic              lt_n,
    input  logic              blank,
`ifdef UBCD_SCAN_BLINK_EN
    input  logic [DIGITS-1:0] blink,
`endif
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig,
    output logic              frame
);

    localparam int unsigned   PW     = $clog2(PRESCALE);
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [AW-1:0] S_LAST = AW'(DIGITS - 1);

    // Segment glyphs, {g,f,e,d,c,b,a}
    function automatic logic [6:0] bcd_glyph(input logic [3:0] v);
        logic [6:0] g;
        unique case (v)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] ascii_glyph(input logic [6:0] c);
        logic [6:0] g;
        if (c >= 7'h30 && c <= 7'h39) begin
            g = bcd_glyph(c[3:0]);
        end else begin
            unique case (c)
                7'h41, 7'h61: g = 7'h77;  // A
                7'h42, 7'h62: g = 7'h7C;  // b
                7'h43, 7'h63: g = 7'h39;  // C
                7'h44, 7'h64: g = 7'h5E;  // d
                7'h45, 7'h65: g = 7'h79;  // E
                7'h46, 7'h66: g = 7'h71;  // F
                7'h2D:        g = 7'h40;  // -
                7'h5F:        g = 7'h08;  // _
                default:      g = 7'h00;
            endcase
        end
        return g;
    endfunction

    // State
    logic [PW-1:0]     presc_q, presc_d;
    logic [AW-1:0]     slot_q, slot_d;
    logic [7:0]        code_q [DIGITS];
    logic [7:0]        latch_q, latch_d;
    logic              flag_q, flag_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dig_q, dig_d;
    logic              frame_q, frame_d;
    logic              blink_off;

    logic              presc_last;
    logic              dead;
    logic [6:0]        dec_d;
    logic [3:0]        dec_bcd;
    logic              dec_ascii;
    logic              rbi;
    logic              rbo;
    logic [6:0]        dec_seg;

    assign presc_last = (presc_q == P_LAST);
    assign dead       = (presc_q == '0);

    // Scan timing
    always_comb begin
        presc_d = presc_last ? '0 : presc_q + 1'b1;
        slot_d  = slot_q;
        if (presc_last) begin
            slot_d = (slot_q == '0) ? S_LAST : slot_q - 1'b1;
        end
        // The slot latch is loaded on the dead cycle so a write during the lit part of the
        // slot never changes the digit currently shown.
        latch_d = dead ? code_q[slot_q] : latch_q;
    end

    // Decoder pin drive: the decoder reads BCD bits A,B,C,D from pins D0,D6,D5,D1, so the
    // nibble is routed onto those pins; ASCII codes drive D0..D6 straight.
    always_comb begin
        dec_d = latch_q[6:0];
        if (!latch_q[7]) begin
            dec_d = {latch_q[1], latch_q[2], 3'b000, latch_q[3], latch_q[0]};
        end
    end

    assign dec_ascii = latch_q[7];
    assign dec_bcd   = {dec_d[1], dec_d[5], dec_d[6], dec_d[0]};

    // Digit 0 never takes RBI so an all-zero display still shows one "0".
    assign rbi = (slot_q != '0) && ((rbz && (slot_q == S_LAST)) || flag_q);
    assign rbo = rbi && !dec_ascii && (dec_bcd == 4'd0);

    always_comb begin
        if (blank) begin
            dec_seg = 7'h00;
        end else if (!lt_n) begin
            dec_seg = 7'h7F;
        end else if (dec_ascii) begin
            dec_seg = ascii_glyph(dec_d);
        end else if (rbo) begin
            dec_seg = 7'h00;
        end else begin
            dec_seg = bcd_glyph(dec_bcd);
        end
    end

    // Ripple flag carries RBO from the end of one slot into the next, less significant one.
    always_comb begin
        flag_d = flag_q;
        if (!rbz) begin
            flag_d = 1'b0;
        end else if (presc_last) begin
            flag_d = rbo;
        end
    end

    always_comb begin
        seg_d   = (dead || blink_off) ? 7'h00 : dec_seg;
        dig_d   = dead ? '0 : (DIGITS'(1) << slot_q);
        frame_d = dead && (slot_q == '0);
    end

`ifdef UBCD_SCAN_BLINK_EN
    logic [4:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_d) begin
            frame_cnt_q <= frame_cnt_q + 5'd1;
        end
    end

    assign blink_off = blink[slot_q] && frame_cnt_q[4];
`else
    assign blink_off = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                code_q[i] <= '0;
            end
        end else if (we && (32'(waddr) < DIGITS)) begin
            code_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            slot_q  <= S_LAST;
            latch_q <= '0;
            flag_q  <= 1'b0;
            seg_q   <= '0;
            dig_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            slot_q  <= slot_d;
            latch_q <= latch_d;
            flag_q  <= flag_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dig   = dig_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_ubcd_scan_driver.sv
`timescale 1ns/1ps
module tb_ubcd_scan_driver;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned PRESCALE = 8;
    localparam int unsigned AW       = 2;

    localparam logic [6:0] NUM_FONT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam logic [6:0] HEX_FONT [6]  = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              we    = 1'b0;
    logic [AW-1:0]     waddr = '0;
    logic [7:0]        wdata = '0;
    logic              rbz   = 1'b0;
    logic              lt_n  = 1'b1;
    logic              blank = 1'b0;
    logic [DIGITS-1:0] blink = '0;
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig;
    logic              frame;

    ubcd_scan_driver #(
        .DIGITS  (DIGITS),
        .PRESCALE(PRESCALE)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .rbz  (rbz),
        .lt_n (lt_n),
        .blank(blank),
`ifdef UBCD_SCAN_BLINK_EN
        .blink(blink),
`endif
        .seg  (seg),
        .dig  (dig),
        .frame(frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: position in the scan, host-visible codes, per-slot snapshots
    int                m_p;
    int                m_slot;
    logic [7:0]        m_code [DIGITS];
    logic [7:0]        snap   [DIGITS];
    logic [4:0]        fcnt;
    logic [6:0]        exp_seg;
    logic [DIGITS-1:0] exp_dig;
    logic              exp_frame;

    function automatic logic [6:0] ascii_font(input logic [6:0] c);
        int u;
        u = int'(c);
        if (u >= 97 && u <= 122) u = u - 32;
        if (u >= 48 && u <= 57) return NUM_FONT[u - 48];
        if (u >= 65 && u <= 70) return HEX_FONT[u - 65];
        if (u == 45) return 7'h40;
        if (u == 95) return 7'h08;
        return 7'h00;
    endfunction

    function automatic logic blinked(input int s);
`ifdef UBCD_SCAN_BLINK_EN
        return blink[s] && fcnt[4];
`else
        return (s < 0);
`endif
    endfunction

    function automatic logic [6:0] exp_glyph(input logic [7:0] code, input logic lead,
                                             input int s);
        int v;
        if (blank || blinked(s)) return 7'h00;
        if (!lt_n) return 7'h7F;
        if (code[7]) return ascii_font(code[6:0]);
        if (lead) return 7'h00;
        v = int'(code[3:0]);
        return (v <= 9) ? NUM_FONT[v] : 7'h00;
    endfunction

    task automatic model_reset();
        m_p    = 0;
        m_slot = DIGITS - 1;
        fcnt   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            m_code[i] = '0;
            snap[i]   = '0;
        end
        exp_seg   = '0;
        exp_dig   = '0;
        exp_frame = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs presented for that edge.
    task automatic model_step();
        logic lead;
        exp_frame = (m_p == 0) && (m_slot == 0);
        if (m_p == 0) begin
            snap[m_slot] = m_code[m_slot];
            exp_dig = '0;
            exp_seg = '0;
            if (m_slot == 0) fcnt = fcnt + 5'd1;
        end else begin
            exp_dig = DIGITS'(1) << m_slot;
            // A digit is a leading zero when it and every more significant digit are BCD 0
            lead = rbz && (m_slot != 0);
            for (int k = m_slot; k < DIGITS; k++) begin
                if (snap[k][7] || snap[k][3:0] != 4'd0) lead = 1'b0;
            end
            exp_seg = exp_glyph(snap[m_slot], lead, m_slot);
        end
        if (we && (int'(waddr) < DIGITS)) m_code[waddr] = wdata;
        if (m_p == PRESCALE - 1) begin
            m_p    = 0;
            m_slot = (m_slot == 0) ? DIGITS - 1 : m_slot - 1;
        end else begin
            m_p++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("seg", 32'(seg), 32'(exp_seg));
        check_eq("dig", 32'(dig), 32'(exp_dig));
        check_eq("frame", 32'(frame), 32'(exp_frame));
        we = 1'b0;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        we    = 1'b1;
        waddr = AW'(a);
        wdata = d;
        tick();
    endtask

    // rbz only changes ahead of the most significant slot so a frame sees one value
    task automatic set_rbz(input logic v);
        while (m_slot != DIGITS - 1) tick();
        rbz = v;
    endtask

    task automatic reset_mid();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_seg", 32'(seg), 32'h0);
        check_eq("rst_dig", 32'(dig), 32'h0);
        check_eq("rst_frame", 32'(frame), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_code();
        int sel;
        sel = $urandom_range(0, 3);
        if (sel < 2) return {1'b0, 3'($urandom), 4'd0};
        if (sel == 2) return {1'b0, 3'($urandom), 4'($urandom_range(0, 15))};
        return {1'b1, 7'($urandom_range(32, 127))};
    endfunction

    task automatic random_run(input int n);
        repeat (n) begin
            if ($urandom_range(0, 5) == 0) begin
                we    = 1'b1;
                waddr = AW'($urandom_range(0, DIGITS - 1));
                wdata = rand_code();
            end
            lt_n  = ($urandom_range(0, 15) != 0);
            blank = ($urandom_range(0, 15) == 0);
            if (m_slot == DIGITS - 1 && $urandom_range(0, 7) == 0) rbz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 255) == 0) blink = DIGITS'($urandom);
            tick();
        end
        lt_n  = 1'b1;
        blank = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("por_seg", 32'(seg), 32'h0);
        check_eq("por_dig", 32'(dig), 32'h0);
        check_eq("por_frame", 32'(frame), 32'h0);
        rst_n = 1'b1;

        // Basic scan with codes 1,2,3,4
        wr(3, 8'd1);
        wr(2, 8'd2);
        wr(1, 8'd3);
        wr(0, 8'd4);
        repeat (80) tick();

        // Ripple blanking
        wr(3, 8'd0);
        wr(2, 8'd0);
        wr(1, 8'd0);
        wr(0, 8'd7);
        set_rbz(1'b1);
        repeat (40) tick();
        wr(0, 8'd0);
        repeat (40) tick();
        set_rbz(1'b0);
        repeat (40) tick();

        // ASCII digit breaks the ripple chain
        wr(3, 8'hC1);
        wr(0, 8'd5);
        set_rbz(1'b1);
        repeat (40) tick();

        // Write colliding with the slot-latch sample of digit 2
        while (!(m_p == 0 && m_slot == 2)) tick();
        wr(2, 8'd9);
        repeat (64) tick();

        // Reset in the middle of a lit slot
        while (m_p != 4) tick();
        reset_mid();
        tick();
        check_eq("rel_dig_c1", 32'(dig), 32'h0);
        tick();
        check_eq("rel_dig_c2", 32'(dig), 32'h8);

        // Randomized traffic with blink and lamp test
        blink = DIGITS'(1);
        random_run(2200);
        while (m_p < 2) tick();
        reset_mid();
        random_run(1400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
